// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter/sequencer sharing one non-pipelined fixed-point divider.
// Define FP_DIV_ARB_TIMEOUT_EN to abort requests the divider never answers.
module fp_div_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned WIDTH          = 42,
  parameter int unsigned FRACTION_WIDTH = 10,
  parameter int unsigned TIMEOUT        = 16
) (
  input  logic                                      clk_in,
  input  logic                                      rst_in,
  input  logic [NUM_REQ-1:0]                        req_valid_in,
  input  logic [NUM_REQ*(WIDTH-FRACTION_WIDTH)-1:0] req_dividend_in,
  input  logic [NUM_REQ*(WIDTH-FRACTION_WIDTH)-1:0] req_divisor_in,
  output logic [NUM_REQ-1:0]                        req_ready_out,
  output logic [NUM_REQ-1:0]                        resp_valid_out,
  output logic [FRACTION_WIDTH:0]                   resp_quotient_out,
  output logic                                      resp_err_out,
  output logic [WIDTH-FRACTION_WIDTH-1:0]           div_dividend_out,
  output logic [WIDTH-FRACTION_WIDTH-1:0]           div_divisor_out,
  output logic                                      div_valid_out,
  input  logic [FRACTION_WIDTH:0]                   div_quotient_in,
  input  logic                                      div_valid_in,
  input  logic                                      div_err_in,
  input  logic                                      div_busy_in,
  output logic                                      busy_out
);

  localparam int unsigned OPW = WIDTH - FRACTION_WIDTH;
  localparam int unsigned QW  = FRACTION_WIDTH + 1;
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic [OPW-1:0]     dvd_q, dvd_d;
  logic [OPW-1:0]     dvs_q, dvs_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [QW-1:0]      quot_q, quot_d;
  logic               err_q, err_d;

  logic               grant_vld;
  logic [IDW-1:0]     grant_idx;
  logic               accept;
  logic [OPW-1:0]     sel_dvd, sel_dvs;

`ifdef FP_DIV_ARB_TIMEOUT_EN
  localparam int unsigned TOW = $clog2(TIMEOUT + 1);
  logic [TOW-1:0]     to_cnt_q, to_cnt_d;
`endif

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Search starts one past the last grant and wraps, so requester last+1 has top priority.
  always_comb begin
    int unsigned    cand;
    logic [IDW-1:0] cidx;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cidx      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = 32'(last_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cidx = IDW'(cand);
      if (!grant_vld && req_valid_in[cidx]) begin
        grant_vld = 1'b1;
        grant_idx = cidx;
      end
    end
  end

  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_dvd = req_dividend_in[i*OPW +: OPW];
        sel_dvs = req_divisor_in[i*OPW +: OPW];
      end
    end
  end

  assign accept        = (state_q == IDLE) && !div_busy_in && grant_vld;
  assign req_ready_out = accept ? onehot(grant_idx) : '0;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rvalid_d = '0;
    quot_d   = quot_q;
    err_d    = err_q;
`ifdef FP_DIV_ARB_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          dvd_d   = sel_dvd;
          dvs_d   = sel_dvs;
          owner_d = grant_idx;
          last_d  = grant_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef FP_DIV_ARB_TIMEOUT_EN
        to_cnt_d = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        // A real result in the expiry cycle takes precedence over the abort.
        if (div_valid_in) begin
          quot_d   = div_quotient_in;
          err_d    = div_err_in;
          rvalid_d = onehot(owner_q);
          state_d  = IDLE;
        end
`ifdef FP_DIV_ARB_TIMEOUT_EN
        else if (to_cnt_q == TOW'(TIMEOUT - 1)) begin
          quot_d   = '0;
          err_d    = 1'b1;
          rvalid_d = onehot(owner_q);
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      last_q   <= IDW'(NUM_REQ - 1);
      owner_q  <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rvalid_q <= '0;
      quot_q   <= '0;
      err_q    <= 1'b0;
`ifdef FP_DIV_ARB_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rvalid_q <= rvalid_d;
      quot_q   <= quot_d;
      err_q    <= err_d;
`ifdef FP_DIV_ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign resp_valid_out    = rvalid_q;
  assign resp_quotient_out = quot_q;
  assign resp_err_out      = err_q;
  assign div_dividend_out  = dvd_q;
  assign div_divisor_out   = dvs_q;
  assign div_valid_out     = (state_q == ISSUE);
  assign busy_out          = (state_q != IDLE);

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Scoreboard bench for fp_div_arbiter with a behavioural divider model.
`timescale 1ns/1ps
module tb_fp_div_arbiter;

  localparam int N        = 4;
  localparam int W        = 42;
  localparam int FW       = 10;
  localparam int TO       = 16;
  localparam int OPW      = W - FW;
  localparam int QW       = FW + 1;
  localparam int DIV_LAT  = 9;          // start-pulse cycle to result cycle
  localparam int RESP_LAT = DIV_LAT + 2;
  localparam int TO_LAT   = TO + 2;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic [N-1:0]     req_valid_in = '0;
  logic [N*OPW-1:0] req_dividend_in = '0;
  logic [N*OPW-1:0] req_divisor_in = '0;
  logic [N-1:0]     req_ready_out;
  logic [N-1:0]     resp_valid_out;
  logic [QW-1:0]    resp_quotient_out;
  logic             resp_err_out;
  logic [OPW-1:0]   div_dividend_out;
  logic [OPW-1:0]   div_divisor_out;
  logic             div_valid_out;
  logic [QW-1:0]    div_quotient_in = '0;
  logic             div_valid_in = 1'b0;
  logic             div_err_in = 1'b0;
  logic             div_busy_in;
  logic             busy_out;

  fp_div_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .FRACTION_WIDTH(FW), .TIMEOUT(TO)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_dividend_in(req_dividend_in),
    .req_divisor_in(req_divisor_in), .req_ready_out(req_ready_out),
    .resp_valid_out(resp_valid_out), .resp_quotient_out(resp_quotient_out),
    .resp_err_out(resp_err_out), .div_dividend_out(div_dividend_out),
    .div_divisor_out(div_divisor_out), .div_valid_out(div_valid_out),
    .div_quotient_in(div_quotient_in), .div_valid_in(div_valid_in),
    .div_err_in(div_err_in), .div_busy_in(div_busy_in), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // {err, quotient} of an unsigned fixed-point divide, truncated to QW bits
  function automatic logic [QW:0] ref_div(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    logic [63:0] q;
    if (b == '0) return {1'b1, {QW{1'b0}}};
    q = (64'(a) << FW) / 64'(b);
    return {1'b0, q[QW-1:0]};
  endfunction

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Divider model
  int             mdl_cnt = 0;
  logic           mdl_busy = 1'b0;
  logic           mdl_mute = 1'b0;
  logic           force_busy = 1'b0;
  logic [OPW-1:0] mdl_dvd = '0;
  logic [OPW-1:0] mdl_dvs = '0;
  assign div_busy_in = mdl_busy | force_busy;

  initial forever begin
    @(posedge clk_in); #1;
    div_valid_in = 1'b0;
    if (mdl_cnt > 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        mdl_busy     = 1'b0;
        div_valid_in = 1'b1;
        {div_err_in, div_quotient_in} = ref_div(mdl_dvd, mdl_dvs);
      end
    end
    if (div_valid_out && !mdl_mute) begin
      mdl_dvd  = div_dividend_out;
      mdl_dvs  = div_divisor_out;
      mdl_cnt  = DIV_LAT;
      mdl_busy = 1'b1;
    end
  end

  typedef struct {
    int            owner;
    logic [QW-1:0] quot;
    logic          err;
    int            due;
  } sb_t;

  sb_t            sb[$];
  int             grant_log[$];
  logic [N-1:0]   acc_flag = '0;
  int             last_acc = -10;
  logic [OPW-1:0] exp_dvd = '0;
  logic [OPW-1:0] exp_dvs = '0;
  logic [QW-1:0]  obs_q[N];
  logic           obs_err[N];

  // Monitor: accepts push expectations, response strobes pop and compare.
  always @(negedge clk_in) begin
    sb_t            e;
    logic [OPW-1:0] a, b;
    if (!rst_in) begin
      if (req_valid_in != '0 && div_busy_in)
        check_eq("ready_while_busy", req_ready_out, 0);
      if (req_ready_out != '0)
        check_eq("ready_onehot", $countones(req_ready_out), 1);
      for (int i = 0; i < N; i++) begin
        if (req_valid_in[i] && req_ready_out[i]) begin
          a = req_dividend_in[i*OPW +: OPW];
          b = req_divisor_in[i*OPW +: OPW];
          e.owner = i;
          if (mdl_mute) begin
            e.quot = '0;
            e.err  = 1'b1;
            e.due  = cyc + TO_LAT;
          end else begin
            {e.err, e.quot} = ref_div(a, b);
            e.due = cyc + RESP_LAT;
          end
          sb.push_back(e);
          grant_log.push_back(i);
          acc_flag[i] = 1'b1;
          last_acc = cyc;
          exp_dvd  = a;
          exp_dvs  = b;
        end
      end
      if (div_valid_out) begin
        check_eq("start_cycle", cyc, last_acc + 1);
        check_eq("div_dividend", div_dividend_out, exp_dvd);
        check_eq("div_divisor", div_divisor_out, exp_dvs);
      end
      if (resp_valid_out != '0) begin
        if (sb.size() == 0) begin
          check_eq("resp_unexpected", resp_valid_out, 0);
        end else begin
          e = sb.pop_front();
          check_eq("resp_owner", resp_valid_out, onehot(e.owner));
          check_eq("resp_quot", resp_quotient_out, e.quot);
          check_eq("resp_err", resp_err_out, e.err);
          check_eq("resp_cycle", cyc, e.due);
          obs_q[e.owner]   = resp_quotient_out;
          obs_err[e.owner] = resp_err_out;
        end
      end
    end
  end

  // Requesters drop valid in the cycle after their accept.
  initial forever begin
    @(posedge clk_in); #1;
    for (int i = 0; i < N; i++) begin
      if (acc_flag[i]) begin
        req_valid_in[i] = 1'b0;
        acc_flag[i]     = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  task automatic post(input int i, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    req_dividend_in[i*OPW +: OPW] = a;
    req_divisor_in[i*OPW +: OPW]  = b;
    req_valid_in[i]               = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while ((sb.size() != 0 || req_valid_in != '0 || busy_out || mdl_busy) && n < 300);
    check_eq({tag, "_done"}, (n < 300), 1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      obs_q[i]   = '0;
      obs_err[i] = 1'b0;
    end

    repeat (3) step();
    @(negedge clk_in);
    check_eq("rst_ready", req_ready_out, 0);
    check_eq("rst_resp_valid", resp_valid_out, 0);
    check_eq("rst_resp_quot", resp_quotient_out, 0);
    check_eq("rst_resp_err", resp_err_out, 0);
    check_eq("rst_div_valid", div_valid_out, 0);
    check_eq("rst_div_dvd", div_dividend_out, 0);
    check_eq("rst_div_dvs", div_divisor_out, 0);
    check_eq("rst_busy", busy_out, 0);
    step();
    rst_in = 1'b0;

    // all four at once, starting from reset priority
    step();
    grant_log.delete();
    post(0, 3, 2);
    post(1, 5, 8);
    post(2, 1, 3);
    post(3, 7, 4);
    wait_idle("rr4");
    check_eq("rr4_count", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check_eq($sformatf("rr4_grant%0d", k), grant_log[k], k);
    check_eq("rr4_req2_quot", obs_q[2], 11'h155);

    // single request
    step();
    post(0, 6, 4);
    wait_idle("single");
    check_eq("single_quot", obs_q[0], 11'h600);
    check_eq("single_err", obs_err[0], 0);

    // divide by zero, then a normal request
    step();
    post(1, 9, 0);
    wait_idle("dz");
    check_eq("dz_err", obs_err[1], 1);
    step();
    post(1, 2, 4);
    wait_idle("dz_next");
    check_eq("dz_next_err", obs_err[1], 0);
    check_eq("dz_next_quot", obs_q[1], 11'h200);

    // divider busy holds off the grant
    step();
    force_busy = 1'b1;
    post(3, 3, 5);
    repeat (5) begin
      @(negedge clk_in);
      check_eq("busy_hold_ready", req_ready_out, 0);
    end
    step();
    force_busy = 1'b0;
    @(negedge clk_in);
    check_eq("busy_release_ready", req_ready_out, 4'b1000);
    wait_idle("busy");
    check_eq("busy_quot", obs_q[3], 11'd614);

    // reset during WAIT drops the in-flight result and restores priority
    step();
    post(0, 1, 2);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!(busy_out && mdl_busy && !div_valid_out) && n < 50);
    check_eq("midrst_reach_wait", (n < 50), 1);
    step();
    rst_in = 1'b1;
    sb.delete();
    step();
    rst_in = 1'b0;
    @(negedge clk_in);
    check_eq("midrst_idle", busy_out, 0);
    check_eq("midrst_no_resp", resp_valid_out, 0);
    step();
    grant_log.delete();
    post(0, 1, 4);
    post(1, 1, 8);
    wait_idle("midrst");
    check_eq("midrst_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check_eq("midrst_first", grant_log[0], 0);
      check_eq("midrst_second", grant_log[1], 1);
    end

`ifdef FP_DIV_ARB_TIMEOUT_EN
    // divider never answers
    step();
    mdl_mute = 1'b1;
    post(2, 1, 4);
    wait_idle("tmo");
    mdl_mute = 1'b0;
    check_eq("tmo_err", obs_err[2], 1);
    check_eq("tmo_quot", obs_q[2], 0);
    step();
    post(2, 1, 4);
    wait_idle("tmo_next");
    check_eq("tmo_next_err", obs_err[2], 0);
    check_eq("tmo_next_quot", obs_q[2], 11'h100);
`endif

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

endmodule
